// File: rtl/spi_dep_pkg.sv
// Shared types and defaults for the SPI target front-end.
package spi_dep_pkg;

    // Frame state: waiting for chip select, or inside a CS_n-low frame.
    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } spi_state_e;

    localparam int unsigned DefaultDataW = 8;
    localparam logic [DefaultDataW-1:0] DefaultDummyTx = 8'h00;

endpackage

// File: rtl/spi_dep_edge_detector.sv
// One-bit edge detector on an already-synchronized signal.
module spi_dep_edge_detector #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic async_nreset_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    // Keep a one-cycle delayed copy of the input.
    always_ff @(posedge clk_i or negedge async_nreset_i) begin
        if (!async_nreset_i) begin
            prev_q <= ResetVal;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;
    assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/spi_dep_spi_byte_receiver.sv
// SPI mode-0 target front-end: deserialises MOSI into words, serialises tx words onto MISO.
module spi_dep_spi_byte_receiver
    import spi_dep_pkg::*;
#(
    parameter int unsigned        DATA_W   = DefaultDataW,
    parameter logic [DATA_W-1:0]  DUMMY_TX = DATA_W'(DefaultDummyTx)
) (
    input  logic              clk_i,
    input  logic              async_nreset_i,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              rx_overrun_o,
    output logic              tx_underrun_o,
    output logic              frame_end_o
);

    localparam int unsigned     CntW    = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    logic sclk_rise, sclk_fall;
    logic cs_start, cs_stop;

    spi_dep_edge_detector #(
        .ResetVal (1'b0)
    ) u_sclk_edge (
        .clk_i          (clk_i),
        .async_nreset_i (async_nreset_i),
        .sig_i          (sclk_i),
        .rise_o         (sclk_rise),
        .fall_o         (sclk_fall)
    );

    // CS_n is active-low: its falling edge opens a frame, its rising edge closes it.
    spi_dep_edge_detector #(
        .ResetVal (1'b1)
    ) u_cs_edge (
        .clk_i          (clk_i),
        .async_nreset_i (async_nreset_i),
        .sig_i          (cs_n_i),
        .rise_o         (cs_stop),
        .fall_o         (cs_start)
    );

    spi_state_e        state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d;
    logic              tx_ready_q, tx_ready_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              frame_end_q, frame_end_d;

    logic              do_load;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] load_word;

    assign rx_word   = {rx_shift_q[DATA_W-2:0], mosi_i};
    assign load_word = tx_valid_i ? tx_data_i : DUMMY_TX;

    // Next-state: frame FSM, bit counting, shifting and the rx/tx handshakes.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        miso_d        = miso_q;
        tx_ready_d    = 1'b0;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        frame_end_d   = 1'b0;
        do_load       = 1'b0;

        // A completion later in this block may re-assert valid with the new word.
        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (cs_start) begin
                    state_d   = StActive;
                    bit_cnt_d = '0;
                    do_load   = 1'b1;
                end
            end
            StActive: begin
                if (cs_stop) begin
                    // Partial word is discarded; a pending rx word stays pending.
                    state_d     = StIdle;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    miso_d      = 1'b0;
                    frame_end_d = 1'b1;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_word;
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        if (rx_valid_q && !rx_ready_i) begin
                            rx_overrun_d = 1'b1;
                        end else begin
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[DATA_W-2];
                    end else begin
                        // Falling edge right after a completed word starts the next tx word.
                        do_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_load) begin
            tx_shift_d    = load_word;
            miso_d        = load_word[DATA_W-1];
            tx_ready_d    = tx_valid_i;
            tx_underrun_d = ~tx_valid_i;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge async_nreset_i) begin
        if (!async_nreset_i) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            miso_q        <= 1'b0;
            tx_ready_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            miso_q        <= miso_d;
            tx_ready_q    <= tx_ready_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign miso_o        = miso_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_ready_o    = tx_ready_q;
    assign rx_overrun_o  = rx_overrun_q;
    assign tx_underrun_o = tx_underrun_q;
    assign frame_end_o   = frame_end_q;

endmodule

// File: tb/tb_spi_dep_spi_byte_receiver.sv
// Randomised scoreboard bench for the SPI byte receiver, acting as SPI master and tx producer.
module tb_spi_dep_spi_byte_receiver;

    localparam int unsigned DW    = 8;
    localparam logic [7:0]  DUMMY = 8'hA7;

    logic       clk_i          = 1'b0;
    logic       async_nreset_i = 1'b0;
    logic       sclk_i         = 1'b0;
    logic       cs_n_i         = 1'b1;
    logic       mosi_i         = 1'b0;
    logic       rx_ready_i     = 1'b0;
    logic [7:0] tx_data_i      = 8'h00;
    logic       tx_valid_i     = 1'b0;
    logic       miso_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       tx_ready_o;
    logic       rx_overrun_o;
    logic       tx_underrun_o;
    logic       frame_end_o;

    spi_dep_spi_byte_receiver #(
        .DATA_W   (DW),
        .DUMMY_TX (DUMMY)
    ) dut (
        .clk_i          (clk_i),
        .async_nreset_i (async_nreset_i),
        .sclk_i         (sclk_i),
        .cs_n_i         (cs_n_i),
        .mosi_i         (mosi_i),
        .miso_o         (miso_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .rx_overrun_o   (rx_overrun_o),
        .tx_underrun_o  (tx_underrun_o),
        .frame_end_o    (frame_end_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Producer offers (popped on tx_ready_o) and the model's view of the same offers.
    logic [7:0] offer_q[$];
    logic [7:0] model_q[$];
    // Words the consumer is expected to accept, in order.
    logic [7:0] rx_exp_q[$];
    logic [7:0] cur_tx = 8'h00;
    int half = 2;

    int n_ready = 0, n_underrun = 0, n_overrun = 0, n_fend = 0, n_rxv = 0;
    int exp_ready = 0, exp_underrun = 0, exp_overrun = 0, exp_fend = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push_offer(input logic [7:0] w);
        offer_q.push_back(w);
        model_q.push_back(w);
    endtask

    // Every load takes the oldest offered word, or the dummy word when nothing is offered.
    task automatic do_load();
        if (model_q.size() > 0) begin
            cur_tx = model_q.pop_front();
            exp_ready++;
        end else begin
            cur_tx = DUMMY;
            exp_underrun++;
        end
    endtask

    task automatic frame_begin();
        cs_n_i = 1'b0;
        do_load();
        wait_cyc(half);
    endtask

    task automatic frame_end();
        cs_n_i = 1'b1;
        exp_fend++;
        wait_cyc(2);
        check("miso_idle", {31'd0, miso_o}, 32'd0);
        wait_cyc(half);
    endtask

    // Master shifts nbits of w MSB first; MISO is sampled as SCK rises.
    task automatic send_word(input logic [7:0] w, input int nbits, input bit rdy_last,
                             input bit chk_lat);
        logic [7:0] got;
        logic       last;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            last = (i == DW - 1);
            mosi_i = w[7-i];
            got[7-i] = miso_o;
            if (last) begin
                if (rdy_last) rx_ready_i = 1'b1;
                // A finished word is lost only if an older one is still unaccepted.
                if (rx_exp_q.size() > 0 && !rx_ready_i) exp_overrun++;
                else rx_exp_q.push_back(w);
            end
            sclk_i = 1'b1;
            if (last && chk_lat) begin
                @(negedge clk_i);
                check("lat_before", {31'd0, rx_valid_o}, 32'd0);
                @(negedge clk_i);
                check("lat_valid", {31'd0, rx_valid_o}, 32'd1);
                check("lat_data", {24'd0, rx_data_o}, {24'd0, w});
                @(negedge clk_i);
                check("lat_after", {31'd0, rx_valid_o}, 32'd0);
                wait_cyc(1);
            end else begin
                wait_cyc(half);
            end
            if (last) check("miso_word", {24'd0, got}, {24'd0, cur_tx});
            sclk_i = 1'b0;
            if (last) do_load();
            wait_cyc(half);
        end
    endtask

    task automatic check_counts();
        check("tx_ready_cnt", n_ready, exp_ready);
        check("tx_underrun_cnt", n_underrun, exp_underrun);
        check("rx_overrun_cnt", n_overrun, exp_overrun);
        check("frame_end_cnt", n_fend, exp_fend);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {22'd0, miso_o, rx_data_o, rx_valid_o, tx_ready_o, rx_overrun_o,
                     tx_underrun_o, frame_end_o}, 32'd0);
    endtask

    // Monitor: counts pulses, pops the rx scoreboard on handshakes, and plays tx producer.
    task automatic monitor();
        forever begin
            @(negedge clk_i);
            if (async_nreset_i) begin
                if (tx_ready_o) n_ready++;
                if (tx_underrun_o) n_underrun++;
                if (rx_overrun_o) n_overrun++;
                if (frame_end_o) n_fend++;
                if (rx_valid_o) n_rxv++;
                if (rx_valid_o && rx_ready_i) begin
                    if (rx_exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL rx_spurious: actual word %0h required no word", rx_data_o);
                    end else begin
                        check("rx_data", {24'd0, rx_data_o}, {24'd0, rx_exp_q.pop_front()});
                    end
                end
                if (tx_ready_o && offer_q.size() > 0) offer_q.delete(0);
            end
            tx_valid_i = (offer_q.size() > 0);
            tx_data_i  = (offer_q.size() > 0) ? offer_q[0] : 8'h00;
        end
    endtask

    initial begin
        int nw, noff;
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: actual timeout required finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset values
        #12;
        check_all_zero("reset_outputs");
        wait_cyc(2);
        async_nreset_i = 1'b1;
        wait_cyc(2);

        // 0xA5 with latency check, no tx offered
        rx_ready_i = 1'b1;
        frame_begin();
        send_word(8'hA5, 8, 1'b0, 1'b1);
        frame_end();
        check_counts();

        // Two offered tx words in a two-word frame
        push_offer(8'h3C);
        push_offer(8'hC3);
        frame_begin();
        send_word(8'h5E, 8, 1'b0, 1'b0);
        send_word(8'h81, 8, 1'b0, 1'b0);
        frame_end();
        check_counts();

        // Overrun: consumer stalled across two completions
        rx_ready_i = 1'b0;
        frame_begin();
        send_word(8'h11, 8, 1'b0, 1'b0);
        send_word(8'h22, 8, 1'b0, 1'b0);
        frame_end();
        check("ovr_held_data", {24'd0, rx_data_o}, 32'h11);
        check("ovr_held_valid", {31'd0, rx_valid_o}, 32'd1);
        check_counts();
        rx_ready_i = 1'b1;
        wait_cyc(2);
        check("ovr_drained", rx_exp_q.size(), 0);

        // Accept in the same cycle as the second completion: replace, not overrun
        rx_ready_i = 1'b0;
        frame_begin();
        send_word(8'h33, 8, 1'b0, 1'b0);
        send_word(8'h44, 8, 1'b1, 1'b0);
        frame_end();
        check_counts();
        check("same_cycle_drained", rx_exp_q.size(), 0);

        // Abort after 5 bits, then a clean frame
        frame_begin();
        send_word(8'hFF, 5, 1'b0, 1'b0);
        frame_end();
        frame_begin();
        send_word(8'h5A, 8, 1'b0, 1'b0);
        frame_end();
        check_counts();

        // Nothing offered at frame start; one offer arrives mid-frame for the trailing load
        frame_begin();
        push_offer(8'h96);
        send_word(8'h0F, 8, 1'b0, 1'b0);
        frame_end();
        check_counts();

        // Random frames
        for (int f = 0; f < 20; f++) begin
            half = $urandom_range(2, 4);
            nw   = $urandom_range(1, 3);
            noff = $urandom_range(0, nw + 1);
            for (int k = 0; k < noff; k++) push_offer(8'($urandom_range(0, 255)));
            frame_begin();
            for (int k = 0; k < nw; k++) send_word(8'($urandom_range(0, 255)), 8, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) send_word(8'($urandom_range(0, 255)),
                                                     $urandom_range(1, 7), 1'b0, 1'b0);
            frame_end();
        end
        check_counts();
        check("random_drained", rx_exp_q.size(), 0);

        // Asynchronous reset in the middle of a word
        half = 2;
        frame_begin();
        send_word(8'hC6, 3, 1'b0, 1'b0);
        #3;
        async_nreset_i = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        cs_n_i = 1'b1;
        wait_cyc(2);
        async_nreset_i = 1'b1;
        n_rxv = 0;
        for (int i = 0; i < 10; i++) begin
            mosi_i = 1'($urandom_range(0, 1));
            sclk_i = 1'b1;
            wait_cyc(2);
            sclk_i = 1'b0;
            wait_cyc(2);
        end
        check("no_rx_after_reset", n_rxv, 0);
        check_counts();
        check("final_drained", rx_exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
